// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply,
// restoring divide, WIDTH iterations plus one sign-fix cycle per operation.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               res_neg;
  logic               rem_neg;
  logic               div_zero;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  // Operand decode at issue: op[1] selects divide, op[0] selects unsigned.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    quot_raw  = acc[WIDTH-1:0];
    rem_raw   = acc[2*WIDTH-1:WIDTH];
    prod_fix  = res_neg ? -acc : acc;
    quot_fix  = res_neg ? -quot_raw : quot_raw;
    rem_fix   = rem_neg ? -rem_raw : rem_raw;
  end

  // Multiply keeps the multiplier in acc's low half and the multiplicand in
  // opnd; divide keeps {remainder, dividend/quotient} in acc and the divisor in opnd.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      a_q      <= '0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            cnt      <= '0;
            is_div   <= op[1];
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            div_zero <= op[1] && (b == '0);
            a_q      <= a;
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          if (div_zero) begin
            hi <= a_q;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of MULT/DIV vectors with exact
// cycle-34 timing checks, plus sequences for busy-time writes and reset abort.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issues one op in cycle 0, scrambles the operand buses from cycle 1 on and
  // checks busy over cycles 1..35, the single done pulse and hi/lo at cycle 34.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int busy_bad = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic [31:0] hi34 = '0, lo34 = '0;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = $urandom();
        b = $urandom();
      end
      if (busy !== (k <= 33)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 34) begin
        hi34 = hi;
        lo34 = lo;
      end
    end
    check({nm, " busy_window"}, busy_bad, 0);
    check({nm, " done_count"}, done_cnt, 1);
    check({nm, " done_cycle"}, done_at, 34);
    check({nm, " hi"}, hi34, ehi);
    check({nm, " lo"}, lo34, elo);
  endtask

  initial begin
    int busy_bad, hold_bad, done_cnt, done_at;
    logic [31:0] prev_hi, prev_lo, cap_hi, cap_lo;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5"};
    vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin"};
    vecs[3]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1"};
    vecs[4]  = '{OP_MULTU, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, "multu_zero"};
    vecs[5]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, "mult_7xm2"};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
    vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100d7"};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"};
    vecs[9]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "divu_by0"};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, "div_by0"};
    vecs[11] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
    vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu_maxd1"};
    vecs[13] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, "div_m7dm2"};

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

    // start and MTHI while busy are ignored; hi/lo hold until FIX
    prev_hi = vecs[13].hi;
    prev_lo = vecs[13].lo;
    busy_bad = 0; hold_bad = 0; done_cnt = 0; done_at = -1;
    cap_hi = '0; cap_lo = '0;
    @(negedge clk);
    op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin
        a = 32'h11111111; b = 32'h22222222; op = OP_DIVU;
        start = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
      end
      if (k == 6) begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (k <= 33 && (hi !== prev_hi || lo !== prev_lo)) hold_bad++;
      if (busy !== (k <= 33)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 34) begin
        cap_hi = hi;
        cap_lo = lo;
      end
    end
    check("busy_ignore hold", hold_bad, 0);
    check("busy_ignore busy_window", busy_bad, 0);
    check("busy_ignore done_count", done_cnt, 1);
    check("busy_ignore done_cycle", done_at, 34);
    check("busy_ignore hi", cap_hi, 32'h0);
    check("busy_ignore lo", cap_lo, 32'd12);

    // MTHI / MTLO in idle, then both together
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", hi, 32'hAAAA5555);
    lo_we = 1'b1; wdata = 32'h0000FFFF;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", lo, 32'h0000FFFF);
    check("mtlo hi_held", hi, 32'hAAAA5555);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h13579BDF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both hi", hi, 32'h13579BDF);
    check("mt_both lo", lo, 32'h13579BDF);

    // DIVU with MTLO in the issue cycle, aborted by reset at cycle 10
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'h00000055;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    check("issue_mt lo", lo, 32'h00000055);
    check("issue_mt busy", busy, 1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0; busy_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_cnt++;
      if (busy !== 1'b0) busy_bad++;
    end
    check("abort no_done", done_cnt, 0);
    check("abort stays_idle", busy_bad, 0);

    run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "after_reset_multu");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
